// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared definitions for the control sequencer: FSM state encoding, opcode
//   class constants, ALU function codes, ALU operand-select codes, branch
//   condition codes, flag bit indices and the decoded control bundle.
//   No ports; imported by opcode_decoder and control_sequencer_unit.
package ctrl_pkg;

  // FSM states. HALT is absorbing until reset.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Opcode classes: 3-bit prefixes (opcode[5:3]) and full 6-bit opcodes.
  localparam logic [2:0] OPC_RTYPE  = 3'b000;
  localparam logic [2:0] OPC_IMM    = 3'b001;
  localparam logic [2:0] OPC_BRANCH = 3'b011;
  localparam logic [5:0] OP_LOAD    = 6'b010000;
  localparam logic [5:0] OP_STORE   = 6'b010001;
  localparam logic [5:0] OP_JAL     = 6'b100000;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  // ALU function codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ALU operand-select codes.
  localparam logic [1:0] SEL_RS_RT   = 2'b00;
  localparam logic [1:0] SEL_RS_IMM  = 2'b01;
  localparam logic [1:0] SEL_PC_IMM  = 2'b10;
  localparam logic [1:0] SEL_RS_ZERO = 2'b11;

  // Branch condition codes (opcode[2:0] of a branch).
  localparam logic [2:0] BR_ZERO  = 3'b000;
  localparam logic [2:0] BR_NZERO = 3'b001;
  localparam logic [2:0] BR_SIGN  = 3'b010;
  localparam logic [2:0] BR_CARRY = 3'b011;

  // Bit positions inside the flags bus.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 2;

  // Decoded control bundle for one instruction.
  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_in_sel;
    logic       reg_select;
    logic       reg_write;
    logic       mem_to_reg;
    logic       data_pc_sel;
    logic [2:0] br_cond;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       illegal;
  } ctrl_t;

  // Branch resolution; unlisted condition codes are never taken.
  function automatic logic branch_taken(input logic [2:0] cc, input logic [2:0] f);
    logic t;
    t = 1'b0;
    case (cc)
      BR_ZERO:  t = f[FLAG_ZERO];
      BR_NZERO: t = ~f[FLAG_ZERO];
      BR_SIGN:  t = f[FLAG_SIGN];
      BR_CARRY: t = f[FLAG_CARRY];
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder
//   Purely combinational opcode -> control bundle translation.
//   Ports:
//     opcode_i  in   6       instruction opcode
//     ctrl_o    out  ctrl_t  ALU function/select, register-file controls and
//                            class flags (load/store/branch/jump/halt/illegal)
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.br_cond = opcode_i[2:0];
    if (opcode_i[5:3] == OPC_RTYPE) begin
      ctrl_o.alu_op     = opcode_i[2:0];
      ctrl_o.alu_in_sel = SEL_RS_RT;
      ctrl_o.reg_select = 1'b1;
      ctrl_o.reg_write  = 1'b1;
    end else if (opcode_i[5:3] == OPC_IMM) begin
      ctrl_o.alu_op     = opcode_i[2:0];
      ctrl_o.alu_in_sel = SEL_RS_IMM;
      ctrl_o.reg_write  = 1'b1;
    end else if (opcode_i == OP_LOAD) begin
      ctrl_o.alu_op     = ALU_ADD;
      ctrl_o.alu_in_sel = SEL_RS_IMM;
      ctrl_o.is_load    = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
    end else if (opcode_i == OP_STORE) begin
      ctrl_o.alu_op     = ALU_ADD;
      ctrl_o.alu_in_sel = SEL_RS_IMM;
      ctrl_o.is_store   = 1'b1;
    end else if (opcode_i[5:3] == OPC_BRANCH) begin
      ctrl_o.alu_op     = ALU_ADD;
      ctrl_o.alu_in_sel = SEL_PC_IMM;
      ctrl_o.is_branch  = 1'b1;
    end else if (opcode_i == OP_JAL) begin
      ctrl_o.alu_op      = ALU_ADD;
      ctrl_o.alu_in_sel  = SEL_PC_IMM;
      ctrl_o.is_jump     = 1'b1;
      ctrl_o.reg_write   = 1'b1;
      ctrl_o.data_pc_sel = 1'b1;
    end else if (opcode_i == OP_HALT) begin
      ctrl_o.is_halt = 1'b1;
    end else begin
      // Undefined opcode: no datapath activity, still retires as a NOP.
      ctrl_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer_unit.sv
// control_sequencer_unit
//   Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM x MEM_LAT] -> WB.
//   Drives registered control strobes for the datapath, computes the next PC,
//   counts retired instructions and records illegal opcodes.
//   Ports:
//     clk, reset (sync, active-low)
//     opcode, flags, PCin, ALUresult, haltext      inputs from datapath / PC
//     RegWrite, MemRead, MemWrite, MemtoReg,
//     DataPCSel, RegSelect, ALUop, ALUinSel         registered control strobes
//     next_address, pc_write                       PC update (pc_write in WB)
//     halt, illegal_op, retired                    status
//     dbg_state_o                                  current FSM state (debug)
//   Every output is a register, so a strobe is stable for the whole state it
//   belongs to; the registers are loaded from the state being entered.
module control_sequencer_unit
  import ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [2:0]        flags,
  input  logic [ADDR_W-1:0] PCin,
  input  logic [ADDR_W-1:0] ALUresult,
  input  logic              haltext,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              DataPCSel,
  output logic              RegSelect,
  output logic [2:0]        ALUop,
  output logic [1:0]        ALUinSel,
  output logic [ADDR_W-1:0] next_address,
  output logic              pc_write,
  output logic              halt,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] retired,
  output logic [2:0]        dbg_state_o
);

  state_e            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d, dec_ctrl;
  logic [3:0]        mem_cnt_q, mem_cnt_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [1:0]        alu_in_sel_q, alu_in_sel_d;
  logic              reg_select_q, reg_select_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              data_pc_sel_q, data_pc_sel_d;
  logic              pc_write_q, pc_write_d;
  logic              halt_q, halt_d;
  logic              take_target;

  opcode_decoder u_dec (
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    mem_cnt_d     = mem_cnt_q;
    next_addr_d   = next_addr_q;
    retired_d     = retired_q;
    illegal_d     = illegal_q;
    alu_op_d      = '0;
    alu_in_sel_d  = '0;
    reg_select_d  = 1'b0;
    reg_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_to_reg_d  = 1'b0;
    data_pc_sel_d = 1'b0;
    pc_write_d    = 1'b0;
    halt_d        = 1'b0;
    take_target   = 1'b0;

    // Next-state logic.
    case (state_q)
      ST_FETCH: begin
        if (!haltext) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Latch the decode once; the rest of the instruction runs from it.
        ctrl_d    = dec_ctrl;
        illegal_d = illegal_q | dec_ctrl.illegal;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        // Flags, PCin and ALUresult matter only on this edge.
        take_target = ctrl_q.is_jump |
                      (ctrl_q.is_branch & branch_taken(ctrl_q.br_cond, flags));
        next_addr_d = take_target ? ALUresult : (PCin + ADDR_W'(1));
        if (ctrl_q.is_halt) begin
          state_d = ST_HALT;
        end else if (ctrl_q.is_load | ctrl_q.is_store) begin
          state_d   = ST_MEM;
          mem_cnt_d = 4'(MEM_LAT - 1);
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        // mem_cnt_q counts the MEM cycles still to go after this one.
        if (mem_cnt_q == 4'd0) state_d = ST_WB;
        else                   mem_cnt_d = mem_cnt_q - 4'd1;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase

    // Output registers are loaded for the state being entered.
    case (state_d)
      ST_EXEC: begin
        alu_op_d     = ctrl_d.alu_op;
        alu_in_sel_d = ctrl_d.alu_in_sel;
        reg_select_d = ctrl_d.reg_select;
      end
      ST_MEM: begin
        alu_op_d     = ctrl_d.alu_op;
        alu_in_sel_d = ctrl_d.alu_in_sel;
        reg_select_d = ctrl_d.reg_select;
        mem_read_d   = ctrl_d.is_load;
        mem_write_d  = ctrl_d.is_store;
      end
      ST_WB: begin
        alu_op_d      = ctrl_d.alu_op;
        alu_in_sel_d  = ctrl_d.alu_in_sel;
        reg_select_d  = ctrl_d.reg_select;
        reg_write_d   = ctrl_d.reg_write;
        mem_to_reg_d  = ctrl_d.mem_to_reg;
        data_pc_sel_d = ctrl_d.data_pc_sel;
        pc_write_d    = 1'b1;
        // Count on entry so the new value is visible alongside pc_write.
        retired_d     = retired_q + ADDR_W'(1);
      end
      ST_HALT: halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      ctrl_q        <= '0;
      mem_cnt_q     <= '0;
      next_addr_q   <= '0;
      retired_q     <= '0;
      illegal_q     <= 1'b0;
      alu_op_q      <= '0;
      alu_in_sel_q  <= '0;
      reg_select_q  <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      data_pc_sel_q <= 1'b0;
      pc_write_q    <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      mem_cnt_q     <= mem_cnt_d;
      next_addr_q   <= next_addr_d;
      retired_q     <= retired_d;
      illegal_q     <= illegal_d;
      alu_op_q      <= alu_op_d;
      alu_in_sel_q  <= alu_in_sel_d;
      reg_select_q  <= reg_select_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      data_pc_sel_q <= data_pc_sel_d;
      pc_write_q    <= pc_write_d;
      halt_q        <= halt_d;
    end
  end

  assign RegWrite     = reg_write_q;
  assign MemRead      = mem_read_q;
  assign MemWrite     = mem_write_q;
  assign MemtoReg     = mem_to_reg_q;
  assign DataPCSel    = data_pc_sel_q;
  assign RegSelect    = reg_select_q;
  assign ALUop        = alu_op_q;
  assign ALUinSel     = alu_in_sel_q;
  assign next_address = next_addr_q;
  assign pc_write     = pc_write_q;
  assign halt         = halt_q;
  assign illegal_op   = illegal_q;
  assign retired      = retired_q;
  assign dbg_state_o  = state_q;

endmodule
